// File: rtl/irr_priority_resolver.sv
// Interrupt request front end: latches IR lines into the IRR and picks a fully nested,
// rotating-priority one-hot winner for the in-service block and the INTA sequencer.
module irr_priority_resolver (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ir_in_i,
    input  logic       ltim_i,
    input  logic [7:0] imr_i,
    input  logic [7:0] interrupts_in_service_i,
    input  logic       freeze_i,
    input  logic       ack_i,
    input  logic       rotate_set_i,
    input  logic [2:0] rotate_level_i,
    input  logic       eoi_rotate_i,
    input  logic [2:0] eoi_level_i,
    output logic [7:0] irr_o,
    output logic [7:0] priority_o,
    output logic       int_req_o,
    output logic [2:0] lowest_prio_o
);

    logic [7:0] irr_q, irr_d;
    logic [7:0] ir_prev_q;
    logic [7:0] priority_q, priority_d;
    logic [2:0] lowest_q, lowest_d;

    logic [7:0]  clrMask;
    logic [7:0]  setMask;
    logic [7:0]  candidates;
    logic [3:0]  shamt;
    logic [15:0] candDbl;
    logic [15:0] isrDbl;
    logic [7:0]  candRot;
    logic [7:0]  isrRot;
    logic        found;
    logic        blocked;
    logic [2:0]  winPos;
    logic [2:0]  winLevel;

    // In edge mode a new edge beats a simultaneous ack; in level mode the ack wins for one cycle.
    always_comb begin
        clrMask = ack_i ? priority_q : 8'h00;
        setMask = ir_in_i & ~ir_prev_q & {8{~freeze_i}};
        if (ltim_i) begin
            if (freeze_i) begin
                irr_d = ir_in_i & irr_q & ~clrMask;
            end else begin
                irr_d = ir_in_i & ~clrMask;
            end
        end else begin
            irr_d = (irr_q & ~clrMask) | setMask;
        end
    end

    always_comb begin
        lowest_d = lowest_q;
        if (rotate_set_i) begin
            lowest_d = rotate_level_i;
        end else if (eoi_rotate_i) begin
            lowest_d = eoi_level_i;
        end
    end

    // Rotate so that position 0 is the highest-priority level (L+1), then scan upward.
    always_comb begin
        candidates = irr_q & ~imr_i;
        shamt      = {1'b0, lowest_q} + 4'd1;
        candDbl    = {candidates, candidates} >> shamt;
        isrDbl     = {interrupts_in_service_i, interrupts_in_service_i} >> shamt;
        candRot    = candDbl[7:0];
        isrRot     = isrDbl[7:0];
        found      = 1'b0;
        blocked    = 1'b0;
        winPos     = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (!found) begin
                if (isrRot[j]) begin
                    blocked = 1'b1;
                end
                if (candRot[j]) begin
                    found  = 1'b1;
                    winPos = 3'(j);
                end
            end
        end
        winLevel   = lowest_q + 3'd1 + winPos;
        priority_d = (found && !blocked) ? (8'h01 << winLevel) : 8'h00;
        if (freeze_i) begin
            priority_d = priority_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irr_q      <= 8'h00;
            ir_prev_q  <= 8'h00;
            priority_q <= 8'h00;
            lowest_q   <= 3'd7;
        end else begin
            irr_q      <= irr_d;
            ir_prev_q  <= ir_in_i;
            priority_q <= priority_d;
            lowest_q   <= lowest_d;
        end
    end

    assign irr_o         = irr_q;
    assign priority_o    = priority_q;
    assign int_req_o     = |priority_q;
    assign lowest_prio_o = lowest_q;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Directed bench for irr_priority_resolver: each task drives one scenario and checks
// IRR, priority and rotation state against hand-computed values.
module tb_irr_priority_resolver;

    logic       clk;
    logic       rst;
    logic [7:0] irIn;
    logic       ltim;
    logic [7:0] imr;
    logic [7:0] isr;
    logic       freeze;
    logic       ack;
    logic       rotateSet;
    logic [2:0] rotateLevel;
    logic       eoiRotate;
    logic [2:0] eoiLevel;
    logic [7:0] irr;
    logic [7:0] prio;
    logic       intReq;
    logic [2:0] lowestPrio;

    int testCount = 0;
    int failCount = 0;

    irr_priority_resolver dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .ir_in_i                 (irIn),
        .ltim_i                  (ltim),
        .imr_i                   (imr),
        .interrupts_in_service_i (isr),
        .freeze_i                (freeze),
        .ack_i                   (ack),
        .rotate_set_i            (rotateSet),
        .rotate_level_i          (rotateLevel),
        .eoi_rotate_i            (eoiRotate),
        .eoi_level_i             (eoiLevel),
        .irr_o                   (irr),
        .priority_o              (prio),
        .int_req_o               (intReq),
        .lowest_prio_o           (lowestPrio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; irIn = 8'h00; ltim = 1'b0; imr = 8'h00; isr = 8'h00;
        freeze = 1'b0; ack = 1'b0; rotateSet = 1'b0; rotateLevel = 3'd0;
        eoiRotate = 1'b0; eoiLevel = 3'd0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        rst = 1'b1;
        tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL reset_irr got %h expected 00", irr); end
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL reset_prio got %h expected 00", prio); end
        testCount++; if (intReq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_intreq got %b expected 0", intReq); end
        testCount++; if (lowestPrio !== 3'd7) begin failCount++; $display("[TB] FAIL reset_lowest got %0d expected 7", lowestPrio); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_edge_basic();
        doReset();
        irIn = 8'h04; tick();
        testCount++; if (irr !== 8'h04) begin failCount++; $display("[TB] FAIL edge_irr_set got %h expected 04", irr); end
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL edge_prio_latency got %h expected 00", prio); end
        irIn = 8'h00; tick();
        testCount++; if (prio !== 8'h04) begin failCount++; $display("[TB] FAIL edge_prio got %h expected 04", prio); end
        testCount++; if (intReq !== 1'b1) begin failCount++; $display("[TB] FAIL edge_intreq got %b expected 1", intReq); end
        ack = 1'b1; tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL edge_ack_irr got %h expected 00", irr); end
        ack = 1'b0; tick();
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL edge_ack_prio got %h expected 00", prio); end
        testCount++; if (intReq !== 1'b0) begin failCount++; $display("[TB] FAIL edge_ack_intreq got %b expected 0", intReq); end
    endtask

    task automatic test_set_wins();
        doReset();
        irIn = 8'h04; tick();
        irIn = 8'h00; tick();
        irIn = 8'h04; ack = 1'b1; tick();
        testCount++; if (irr !== 8'h04) begin failCount++; $display("[TB] FAIL set_wins_irr got %h expected 04", irr); end
        ack = 1'b0; tick();
        testCount++; if (prio !== 8'h04) begin failCount++; $display("[TB] FAIL set_wins_prio got %h expected 04", prio); end
    endtask

    task automatic test_rotate();
        doReset();
        irIn = 8'h41; tick();
        irIn = 8'h00; tick();
        testCount++; if (prio !== 8'h01) begin failCount++; $display("[TB] FAIL rot_default_prio got %h expected 01", prio); end
        rotateSet = 1'b1; rotateLevel = 3'd0; tick();
        testCount++; if (lowestPrio !== 3'd0) begin failCount++; $display("[TB] FAIL rot_set_lowest got %0d expected 0", lowestPrio); end
        rotateSet = 1'b0; tick();
        testCount++; if (prio !== 8'h40) begin failCount++; $display("[TB] FAIL rot_prio got %h expected 40", prio); end
        rotateSet = 1'b1; rotateLevel = 3'd5; eoiRotate = 1'b1; eoiLevel = 3'd3; tick();
        testCount++; if (lowestPrio !== 3'd5) begin failCount++; $display("[TB] FAIL rot_both_lowest got %0d expected 5", lowestPrio); end
        rotateSet = 1'b0; eoiLevel = 3'd3; tick();
        testCount++; if (lowestPrio !== 3'd3) begin failCount++; $display("[TB] FAIL rot_eoi_lowest got %0d expected 3", lowestPrio); end
        eoiRotate = 1'b0; tick();
        testCount++; if (prio !== 8'h40) begin failCount++; $display("[TB] FAIL rot_eoi_prio got %h expected 40", prio); end
        eoiRotate = 1'b1; eoiLevel = 3'd6; tick();
        eoiRotate = 1'b0; tick();
        testCount++; if (prio !== 8'h01) begin failCount++; $display("[TB] FAIL rot_l6_prio got %h expected 01", prio); end
    endtask

    task automatic test_nesting();
        doReset();
        irIn = 8'h48; tick();
        irIn = 8'h00; isr = 8'h04; tick();
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL nest_block_prio got %h expected 00", prio); end
        testCount++; if (intReq !== 1'b0) begin failCount++; $display("[TB] FAIL nest_block_intreq got %b expected 0", intReq); end
        isr = 8'h10; tick();
        testCount++; if (prio !== 8'h08) begin failCount++; $display("[TB] FAIL nest_lower_isr_prio got %h expected 08", prio); end
        isr = 8'h08; tick();
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL nest_equal_prio got %h expected 00", prio); end
    endtask

    task automatic test_mask();
        doReset();
        imr = 8'h01; irIn = 8'h03; tick();
        irIn = 8'h00; tick();
        testCount++; if (prio !== 8'h02) begin failCount++; $display("[TB] FAIL mask_prio got %h expected 02", prio); end
        imr = 8'h00; tick();
        testCount++; if (prio !== 8'h01) begin failCount++; $display("[TB] FAIL unmask_prio got %h expected 01", prio); end
        imr = 8'h01; isr = 8'h01; tick();
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL masked_isr_prio got %h expected 00", prio); end
    endtask

    task automatic test_level();
        doReset();
        ltim = 1'b1; irIn = 8'h20; tick();
        testCount++; if (irr !== 8'h20) begin failCount++; $display("[TB] FAIL level_irr got %h expected 20", irr); end
        tick();
        testCount++; if (prio !== 8'h20) begin failCount++; $display("[TB] FAIL level_prio got %h expected 20", prio); end
        ack = 1'b1; tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL level_ack_irr got %h expected 00", irr); end
        ack = 1'b0; tick();
        testCount++; if (irr !== 8'h20) begin failCount++; $display("[TB] FAIL level_reset_irr got %h expected 20", irr); end
        irIn = 8'h00; tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL level_drop_irr got %h expected 00", irr); end
        tick();
        testCount++; if (intReq !== 1'b0) begin failCount++; $display("[TB] FAIL level_drop_intreq got %b expected 0", intReq); end
        ltim = 1'b0;
    endtask

    task automatic test_freeze();
        doReset();
        irIn = 8'h02; tick();
        irIn = 8'h00; tick();
        freeze = 1'b1; irIn = 8'h01; tick();
        testCount++; if (irr !== 8'h02) begin failCount++; $display("[TB] FAIL freeze_irr got %h expected 02", irr); end
        testCount++; if (prio !== 8'h02) begin failCount++; $display("[TB] FAIL freeze_prio got %h expected 02", prio); end
        tick();
        freeze = 1'b0; tick();
        testCount++; if (irr !== 8'h02) begin failCount++; $display("[TB] FAIL freeze_lost_irr got %h expected 02", irr); end
        testCount++; if (prio !== 8'h02) begin failCount++; $display("[TB] FAIL freeze_after_prio got %h expected 02", prio); end
        freeze = 1'b1; ack = 1'b1; tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL freeze_ack_irr got %h expected 00", irr); end
        testCount++; if (prio !== 8'h02) begin failCount++; $display("[TB] FAIL freeze_ack_prio got %h expected 02", prio); end
        freeze = 1'b0; ack = 1'b0; tick();
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL unfreeze_prio got %h expected 00", prio); end
    endtask

    task automatic test_reset_mid();
        doReset();
        irIn = 8'h10; tick();
        irIn = 8'h00; rotateSet = 1'b1; rotateLevel = 3'd2; tick();
        rotateSet = 1'b0; tick();
        rst = 1'b1; ack = 1'b1; rotateSet = 1'b1; rotateLevel = 3'd4; irIn = 8'h08; tick();
        testCount++; if (irr !== 8'h00) begin failCount++; $display("[TB] FAIL midrst_irr got %h expected 00", irr); end
        testCount++; if (prio !== 8'h00) begin failCount++; $display("[TB] FAIL midrst_prio got %h expected 00", prio); end
        testCount++; if (lowestPrio !== 3'd7) begin failCount++; $display("[TB] FAIL midrst_lowest got %0d expected 7", lowestPrio); end
        rst = 1'b0; ack = 1'b0; rotateSet = 1'b0; tick();
        testCount++; if (irr !== 8'h08) begin failCount++; $display("[TB] FAIL release_edge_irr got %h expected 08", irr); end
        tick();
        testCount++; if (prio !== 8'h08) begin failCount++; $display("[TB] FAIL release_edge_prio got %h expected 08", prio); end
    endtask

    // Scenarios run back to back; each starts from a fresh reset.
    initial begin
        test_reset();
        test_edge_basic();
        test_set_wins();
        test_rotate();
        test_nesting();
        test_mask();
        test_level();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/irr_priority_resolver.md
# irr_priority_resolver

Front end of the 8259 interrupt path: latches IR0–IR7 into the Interrupt Request Register (IRR) and applies masking, fully nested priority against the in-service set, and rotating priority. It registers a one-hot winner on `priority`, which drives the ISR block directly, and raises `int_req` toward the control/INTA sequencer. The ISR block feeds its `interrupts_in_service` vector back here so that a request only wins if it outranks every in-service level.

## Interface
Parameters:
- none (fixed 8 IR lines, 3-bit level encoding)

Ports:
- `clk`  in  1  — single clock, all state on rising edge
- `rst`  in  1  — synchronous, active-high reset
- `ir_in`  in  8  — raw interrupt request lines, already synchronous to `clk`
- `ltim`  in  1  — 1 = level-triggered, 0 = edge-triggered (ICW1 LTIM)
- `imr`  in  8  — mask register; bit=1 masks that IR
- `interrupts_in_service`  in  8  — ISR contents fed back from the ISR block
- `freeze`  in  1  — high during an INTA sequence; holds IRR sets and the `priority` output
- `ack`  in  1  — one-cycle pulse; clears the IRR bit currently selected by `priority`
- `rotate_set`  in  1  — one-cycle pulse; load lowest-priority level from `rotate_level` (OCW2 set priority)
- `rotate_level`  in  3  — level loaded by `rotate_set`
- `eoi_rotate`  in  1  — one-cycle pulse; rotate on EOI, load lowest-priority level from `eoi_level`
- `eoi_level`  in  3  — level of the IR just retired by EOI
- `irr`  out  8  — current IRR contents
- `priority`  out  8  — registered one-hot winner, 0 if none; drives ISR `priority`
- `int_req`  out  1  — OR-reduction of `priority`
- `lowest_prio`  out  3  — current lowest-priority level L

## Operation
- Reset values: `irr`=0, `ir_prev`=0, `priority`=0, `int_req`=0, `lowest_prio`=7 (IR0 highest). A line that is high when reset is released counts as a rising edge on the first cycle.
- Edge mode (`ltim`=0):
  - IRR bit i sets when `ir_in[i]`=1 and `ir_prev[i]`=0.
  - It clears only on `ack` while `priority[i]`=1.
  - A set and a clear on the same bit in the same cycle: the set wins.
- Level mode (`ltim`=1):
  - `irr[i]` <= `ir_in[i]` every cycle.
  - `ack` forces bit i to 0 for that cycle only; it re-sets next cycle if the line is still high.
- `ir_prev` <= `ir_in` every cycle, regardless of `freeze`.
- While `freeze`=1:
  - No IRR bit sets.
  - `ack` clears still apply.
  - Edges arriving during `freeze` are lost in edge mode.
- Priority order is L+1, L+2, …, L+8 (mod 8), highest first.
- Candidate set = `irr & ~imr`. The winner is the highest-order candidate.
- Fully nested check: the winner is output only if no `interrupts_in_service` bit ranks equal or higher in the current order; otherwise `priority`=0.
- Masked in-service bits still block lower levels (special mask mode is out of scope).
- Rotation:
  - `rotate_set`: L <= `rotate_level`.
  - `eoi_rotate`: L <= `eoi_level`.
  - Both in the same cycle: `rotate_set` wins.
  - L changes take effect on the next `priority` computation.

## Timing
- `ir_in` edge sampled at edge k → `irr` set after edge k → `priority`/`int_req` valid after edge k+1. Total latency is 2 cycles.
- `priority` is recomputed each edge from registered `irr`, `imr`, `interrupts_in_service` and L. When `freeze`=1 it holds its value.
- `ack` at edge k clears the IRR bit after edge k. `priority` reflects the updated `irr` and ISR after edge k+1, provided `freeze` is low.
- `imr` change at edge k → reflected in `priority` after edge k+1.
- Reset asserted mid-operation: all state returns to reset values at that edge, overriding any simultaneous `ack`, rotate, or edge.

## Test plan
- Reset, edge mode, all `imr`=0: pulse `ir_in`=8'h04 → `irr`=8'h04 after 1 cycle; `priority`=8'h04 and `int_req`=1 after 2 cycles; `ack` → `irr`=0, `priority`=0.
- Simultaneous `ir_in`=8'h41 with L=7 → `priority`=8'h01. Then `rotate_set` with `rotate_level`=0 → `priority`=8'h40 one cycle later.
- Nesting: `interrupts_in_service`=8'h04, `irr`=8'h48 → `priority`=0. Then `interrupts_in_service`=8'h10 → `priority`=8'h08.
- Masking: `irr`=8'h03, `imr`=8'h01 → `priority`=8'h02. Clear `imr` → `priority`=8'h01.
- Level mode: hold `ir_in[5]`=1, `ack` → `irr[5]` low for 1 cycle, then high again. Drop `ir_in[5]` → `irr`=0, `int_req`=0.
- `freeze`=1 with `priority`=8'h02: assert `ir_in[0]` rising → `priority` stays 8'h02 and `irr[0]` stays 0. Deassert `freeze` → `priority` unchanged, IR0 edge lost.
